fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline and the producer side of the IF/ID interface.
//  Issues in-order instruction reads to imem over a valid/ready request, in-order response port.
//  Buffers returned words in a small prefetch FIFO and drives instrD/PCD into the IF/ID register.
//  Honours D-stage stall/flush and the E-stage branch/jump redirect (PCBranchE/PCTargetE).
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  BUF_DEPTH  2              prefetch FIFO entries ({pc,instr}); must be >=1
//  MAX_OUTST  2              max issued-but-unreturned imem requests
//  NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   asynchronous reset, active-low (0 = reset)
//  PCBranchE      in   1   redirect request from E stage
//  PCTargetE      in   32  redirect target address
//  stallD         in   1   hold IF/ID register (hazard unit)
//  flushD         in   1   load bubble into IF/ID register
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   imem accepts request this cycle
//  imem_addr      out  32  fetch address (word aligned)
//  imem_rsp_valid in   1   response word valid (in request order, >=1 cycle after accept)
//  imem_rsp_data  in   32  response instruction word
//  instrD         out  32  IF/ID instruction to decode
//  PCD            out  32  IF/ID PC to decode
//  validD         out  1   1 = instrD is a real fetched instruction, 0 = bubble
// BEHAVIOUR
//  Reset (rst=0, async): fetch PC=RESET_PC, FIFO empty, outst=0, drop=0; instrD=NOP_INSTR,
//   PCD=RESET_PC, validD=0, imem_req_valid=0, imem_addr=RESET_PC.
//  Issue: imem_req_valid = !PCBranchE && outst<MAX_OUTST && (outst-drop)+count<BUF_DEPTH.
//   imem_addr = fetch PC. Accept = valid&&ready -> PC<=PC+4 (32-bit wrap), outst++.
//   addr/valid stay stable while valid&&!ready, except redirect withdraws the request.
//  Response: rsp_valid decrements outst. If drop>0: word discarded, drop--.
//   Else {pc_of_req,data} pushed to FIFO; pc_of_req tracked by a return-PC register advancing by 4,
//   reloaded on redirect. Response and accept in the same cycle: outst unchanged.
//  Redirect (PCBranchE=1): fetch PC<=PCTargetE; return-PC<=PCTargetE; FIFO cleared;
//   drop<=outst after this cycle's response (all in-flight words become stale);
//   no request issued this cycle; IF/ID loads bubble. Redirect overrides stallD and flushD.
//  IF/ID update (priority): redirect or flushD -> bubble (instrD=NOP_INSTR, validD=0, PCD held);
//   else stallD -> hold all three; else FIFO non-empty -> pop head, validD=1;
//   else bubble. FIFO pop only when IF/ID loads from it.
//  FIFO full with response arriving: cannot occur (credit rule); assertion required.
//  Latency: 1-cycle imem, empty pipe: accept at cycle t -> instrD valid from cycle t+3.
//   Steady state 1 instr/cycle when ready=1 and rsp latency 1, BUF_DEPTH=MAX_OUTST=2.
//  No bypass from imem_rsp_data to instrD.
// STRUCTURE
//  Shared package pentarv_pkg: NOP_INSTR, RESET_PC, XLEN=32, ILEN=32.
//  One sub-module: fetch_buffer (BUF_DEPTH x 64-bit FIFO, push/pop/clear, count, full/empty;
//   clear beats push in the same cycle). Top holds PC, return-PC, outst/drop counters, IF/ID reg.
// TESTING
//  1 Reset release, imem ready=1, 1-cycle rsp: addr 0,4,8..; instrD valid at cycle 3, then 1/cycle, PCD=addr.
//  2 imem_req_ready=0 for 5 cycles: addr/valid held at 0x8; no PC advance; instrD bubbles after FIFO drains.
//  3 stallD=1 for 3 cycles: instrD/PCD/validD held; FIFO fills to 2, req_valid drops; no word lost.
//  4 PCBranchE=1 target 0x100 with 2 requests in flight: both stale rsps dropped; next validD=1 has PCD=0x100.
//  5 flushD=1 one cycle: instrD=0x00000013, validD=0; FIFO head delivered next cycle.
//  6 rst low mid-stream with rsp pending: all outputs to reset values same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/pentarv_pkg.sv
// Shared constants and the prefetch entry layout for the pentarv RV32I pipeline.
package pentarv_pkg;
  localparam int          XLEN      = 32;
  localparam int          ILEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetchEntry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO: DEPTH x WIDTH circular buffer, pop data is combinational from the head.
// Push while full is accepted only with a simultaneous pop; clear beats push and pop.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] popData,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr, wrPtr;
  logic             doPush, doPop;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !clear && (!full || pop);
  assign doPop   = pop && !empty && !clear;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= incPtr(wrPtr);
      if (doPop)  rdPtr <= incPtr(rdPtr);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: in-order imem fetch with credit-limited prefetch into IF/ID; accept->instrD is 3 cycles
// with 1-cycle imem. Requests are throttled by outstanding count and buffer space; redirect drops in-flight words.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = pentarv_pkg::RESET_PC,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] NOP_INSTR = pentarv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCBranchE,
  input  logic [31:0] PCTargetE,
  input  logic        stallD,
  input  logic        flushD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic        validD
);
  import pentarv_pkg::*;

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   fetchPc, retPc;
  logic [OW-1:0] outst, dropCnt;
  logic          reqHeld;
  logic [CW-1:0] bufCount;
  logic          bufFull, bufEmpty;
  fetchEntry_t   headEntry, pushEntry;
  logic          accept, rspKeep, pop, loadBubble, credit;

  // Credit counts this cycle's pop so a full-rate stream keeps one request per cycle;
  // once offered, a request stays up until accepted because credit can only grow meanwhile.
  always_comb begin
    loadBubble     = PCBranchE || flushD;
    pop            = !loadBubble && !stallD && !bufEmpty;
    rspKeep        = imem_rsp_valid && (dropCnt == '0);
    credit         = (int'(outst) < MAX_OUTST) &&
                     (int'(outst) - int'(dropCnt) + int'(bufCount) - int'(pop) < BUF_DEPTH);
    imem_req_valid = rst && !PCBranchE && (reqHeld || credit);
    accept         = imem_req_valid && imem_req_ready;
    imem_addr      = fetchPc;
    pushEntry      = '{pc: retPc, instr: imem_rsp_data};
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetchEntry_t))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (rspKeep),
    .pushData (pushEntry),
    .pop      (pop),
    .clear    (PCBranchE),
    .popData  (headEntry),
    .count    (bufCount),
    .full     (bufFull),
    .empty    (bufEmpty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc <= RESET_PC;
      retPc   <= RESET_PC;
      outst   <= '0;
      dropCnt <= '0;
      reqHeld <= 1'b0;
    end else begin
      reqHeld <= imem_req_valid && !imem_req_ready;
      if (PCBranchE) begin
        fetchPc <= PCTargetE;
        retPc   <= PCTargetE;
        outst   <= outst - OW'(imem_rsp_valid);
        dropCnt <= outst - OW'(imem_rsp_valid);
      end else begin
        if (accept)  fetchPc <= fetchPc + 32'd4;
        if (rspKeep) retPc   <= retPc + 32'd4;
        outst <= outst + OW'(accept) - OW'(imem_rsp_valid);
        if (imem_rsp_valid && (dropCnt != '0)) dropCnt <= dropCnt - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instrD <= NOP_INSTR;
      PCD    <= RESET_PC;
      validD <= 1'b0;
    end else if (loadBubble) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (!bufEmpty) begin
        instrD <= headEntry.instr;
        PCD    <= headEntry.pc;
        validD <= 1'b1;
      end else begin
        instrD <= NOP_INSTR;
        validD <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(rspKeep && bufFull && !PCBranchE))
    else $error("fetch_stage: response arrived with prefetch buffer full");
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for stream/stall/flush/ready, hand sequences for reset and redirect.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCBranchE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic        validD;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PCBranchE      (PCBranchE),
    .PCTargetE      (PCTargetE),
    .stallD         (stallD),
    .flushD         (flushD),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instrD         (instrD),
    .PCD            (PCD),
    .validD         (validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // imem model: in-order responses rspLat cycles after accept
  int          edgeCnt = 0;
  int          rspLat  = 1;
  logic [31:0] qa[$];
  int          qd[$];
  always @(posedge clk) begin
    edgeCnt++;
    if (!rst) begin
      qa.delete();
      qd.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      qa.push_back(imem_addr);
      qd.push_back(edgeCnt + rspLat - 1);
    end
    #1;
    if (rst && qa.size() > 0 && qd[0] <= edgeCnt) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = dataOf(qa[0]);
      void'(qa.pop_front());
      void'(qd.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall, flush, ready;
    logic        vd;
    logic [31:0] pcd;
    logic        rv;
    logic [31:0] addr;
  } vec_t;
  vec_t vq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // stream, ready low 5 cycles, stall 3 cycles, single flush
    vq.push_back(vec_t'{0,0,1, 0,32'd0,  1,32'd0 });
    vq.push_back(vec_t'{0,0,1, 0,32'd0,  1,32'd4 });
    vq.push_back(vec_t'{0,0,0, 0,32'd0,  1,32'd8 });
    vq.push_back(vec_t'{0,0,0, 1,32'd0,  1,32'd8 });
    vq.push_back(vec_t'{0,0,0, 1,32'd4,  1,32'd8 });
    vq.push_back(vec_t'{0,0,0, 0,32'd4,  1,32'd8 });
    vq.push_back(vec_t'{0,0,0, 0,32'd4,  1,32'd8 });
    vq.push_back(vec_t'{0,0,1, 0,32'd4,  1,32'd8 });
    vq.push_back(vec_t'{0,0,1, 0,32'd4,  1,32'd12});
    vq.push_back(vec_t'{0,0,1, 0,32'd4,  1,32'd16});
    vq.push_back(vec_t'{0,0,1, 1,32'd8,  1,32'd20});
    vq.push_back(vec_t'{1,0,1, 1,32'd12, 0,32'd24});
    vq.push_back(vec_t'{1,0,1, 1,32'd12, 0,32'd24});
    vq.push_back(vec_t'{1,0,1, 1,32'd12, 0,32'd24});
    vq.push_back(vec_t'{0,0,1, 1,32'd12, 1,32'd24});
    vq.push_back(vec_t'{0,0,1, 1,32'd16, 1,32'd28});
    vq.push_back(vec_t'{0,0,1, 1,32'd20, 1,32'd32});
    vq.push_back(vec_t'{0,1,1, 1,32'd24, 0,32'd36});
    vq.push_back(vec_t'{0,0,1, 0,32'd24, 1,32'd36});
    vq.push_back(vec_t'{0,0,1, 1,32'd28, 1,32'd40});
    vq.push_back(vec_t'{0,0,1, 1,32'd32, 1,32'd44});
    vq.push_back(vec_t'{0,0,1, 1,32'd36, 1,32'd48});

    @(negedge clk);
    chk("reset instrD", instrD, NOP);
    chk("reset PCD", PCD, 32'h0);
    chk("reset validD", {31'b0, validD}, 32'h0);
    chk("reset req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("reset addr", imem_addr, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      stallD = vq[i].stall;
      flushD = vq[i].flush;
      imem_req_ready = vq[i].ready;
      @(negedge clk);
      chk($sformatf("c%0d validD", i), {31'b0, validD}, {31'b0, vq[i].vd});
      chk($sformatf("c%0d PCD", i), PCD, vq[i].pcd);
      chk($sformatf("c%0d instrD", i), instrD, vq[i].vd ? dataOf(vq[i].pcd) : NOP);
      chk($sformatf("c%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vq[i].rv});
      chk($sformatf("c%0d addr", i), imem_addr, vq[i].addr);
      @(posedge clk); #2;
    end

    // asynchronous reset mid-stream with a response on the bus
    #1 rst = 1'b0;
    #1;
    chk("arst instrD", instrD, NOP);
    chk("arst PCD", PCD, 32'h0);
    chk("arst validD", {31'b0, validD}, 32'h0);
    chk("arst req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("arst addr", imem_addr, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("restart req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("restart addr", imem_addr, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("restart validD", {31'b0, validD}, 32'h1);
    chk("restart PCD", PCD, 32'h0);
    chk("restart instrD", instrD, dataOf(32'h0));

    // redirect with two requests in flight (2-cycle imem)
    @(posedge clk); #2;
    rst = 1'b0;
    rspLat = 2;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    PCBranchE = 1'b1;
    PCTargetE = 32'h0000_0100;
    @(negedge clk);
    chk("redir req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("redir pre validD", {31'b0, validD}, 32'h1);
    chk("redir pre PCD", PCD, 32'h4);
    @(posedge clk); #2;
    PCBranchE = 1'b0;
    @(negedge clk);
    chk("redir bubble validD", {31'b0, validD}, 32'h0);
    chk("redir first addr", imem_addr, 32'h100);
    chk("redir first req_valid", {31'b0, imem_req_valid}, 32'h1);
    begin
      int waited;
      waited = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (validD) begin
          waited = i;
          break;
        end
      end
      chk("redir wait cycles", waited, 4);
      chk("redir PCD", PCD, 32'h100);
      chk("redir instrD", instrD, dataOf(32'h100));
      @(posedge clk);
      @(negedge clk);
      chk("redir next validD", {31'b0, validD}, 32'h1);
      chk("redir next PCD", PCD, 32'h104);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
